// File: rtl/mc_pkg.sv
// Shared encodings and default sizes for the multi-core controller.
package mc_pkg;

    // The status output is the state encoding itself.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PROCESS = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ALLDONE = 2'b11
    } mc_state_e;

    localparam int MC_NUM_CORES = 4;
    localparam int MC_CNT_W     = 16;

endpackage

// File: rtl/multicore_controller_done_tracker.sv
// Enable latch, sticky per-core done flags and the all-enabled-cores-done compare.
module done_tracker #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 accum_i,
    input  logic [NUM_CORES-1:0] enable_i,
    input  logic [NUM_CORES-1:0] done_i,
    output logic [NUM_CORES-1:0] done_mask_o,
    output logic                 complete_o
);

    logic [NUM_CORES-1:0] en_q;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] mask_d;

    // Done pulses from cores outside the latched enable set never reach the mask.
    always_comb begin
        mask_d = mask_q | (done_i & en_q);
    end

    // Latch the enable set on an accepted start; accumulate done flags while running.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= '0;
            mask_q <= '0;
        end else if (load_i) begin
            en_q   <= enable_i;
            mask_q <= '0;
        end else if (accum_i) begin
            mask_q <= mask_d;
        end
    end

    // Includes this cycle's done inputs so a core finishing now completes the run now.
    assign complete_o  = (mask_d == en_q);
    assign done_mask_o = mask_q;

endmodule

// File: rtl/multicore_controller.sv
// Run sequencer for NUM_CORES cores: start pulses, completion, timeout, abort.
// Command handshake: begin_process is a level sampled only in IDLE (no edge
// detection); clear is honoured only in ALLDONE/TIMEOUT and abort only in PROCESS.
module multicore_controller
    import mc_pkg::*;
#(
    parameter int NUM_CORES = MC_NUM_CORES,
    parameter int CNT_W     = MC_CNT_W
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 begin_process,
    input  logic [NUM_CORES-1:0] core_enable,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic                 clear,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     timeout_limit,
    output logic [NUM_CORES-1:0] core_start,
    output logic [1:0]           status,
    output logic [NUM_CORES-1:0] done_mask,
    output logic                 all_done,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mc_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CORES-1:0] start_q, start_d;
    logic                 all_done_q, all_done_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 load, accum, complete;

    assign cnt_inc = cnt_q + CNT_ONE;

    done_tracker #(.NUM_CORES(NUM_CORES)) u_tracker (
        .clock       (clock),
        .rst_n       (rst_n),
        .load_i      (load),
        .accum_i     (accum),
        .enable_i    (core_enable),
        .done_i      (core_done),
        .done_mask_o (done_mask),
        .complete_o  (complete)
    );

    // Next state, counter and one-cycle pulses; priority in PROCESS is abort > completion > timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = '0;
        all_done_d = 1'b0;
        load       = 1'b0;
        accum      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (begin_process) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    if (core_enable != '0) begin
                        state_d = ST_PROCESS;
                        start_d = core_enable;
                    end else begin
                        state_d    = ST_ALLDONE;
                        all_done_d = 1'b1;
                    end
                end
            end
            ST_PROCESS: begin
                accum = 1'b1;
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_inc;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (complete) begin
                    state_d    = ST_ALLDONE;
                    all_done_d = 1'b1;
                end else if (timeout_limit != '0 && cnt_inc == timeout_limit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT, ST_ALLDONE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset discards any run in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            start_q    <= '0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            all_done_q <= all_done_d;
        end
    end

    assign status      = state_q;
    assign core_start  = start_q;
    assign all_done    = all_done_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_multicore_controller.sv
// Directed and randomised runs of multicore_controller with a final-result scoreboard.
module tb_multicore_controller;

  localparam int NC = 4;
  localparam int CW = 16;
  localparam int EW = 2 + NC + CW;

  logic          clock;
  logic          rst_n;
  logic          begin_process;
  logic [NC-1:0] core_enable;
  logic [NC-1:0] core_done;
  logic          clear;
  logic          abort;
  logic [CW-1:0] timeout_limit;
  logic [NC-1:0] core_start;
  logic [1:0]    status;
  logic [NC-1:0] done_mask;
  logic          all_done;
  logic [CW-1:0] cycle_count;

  int pass_cnt;
  int chk_cnt;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_w;
  logic [EW-1:0] exp_w;

  logic [NC-1:0] sched[1:32];
  logic [NC-1:0] obs_start[1:32];
  logic [NC-1:0] obs_mask[1:32];
  logic [1:0]    obs_status[1:32];
  logic          obs_alldone[1:32];
  int            abort_at;
  int            end_cyc;

  multicore_controller #(.NUM_CORES(NC), .CNT_W(CW)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .begin_process (begin_process),
    .core_enable   (core_enable),
    .core_done     (core_done),
    .clear         (clear),
    .abort         (abort),
    .timeout_limit (timeout_limit),
    .core_start    (core_start),
    .status        (status),
    .done_mask     (done_mask),
    .all_done      (all_done),
    .cycle_count   (cycle_count)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_sched();
    for (int c = 1; c <= 32; c++) sched[c] = '0;
    abort_at = 0;
  endtask

  task automatic start_run(input logic [NC-1:0] en);
    core_enable   = en;
    begin_process = 1'b1;
    step();
    begin_process = 1'b0;
  endtask

  // Drives cycles 1..max_cyc of a PROCESS run from sched, recording outputs; end_cyc=0 if still running.
  task automatic run_process(input int max_cyc);
    end_cyc = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      obs_start[c] = core_start;
      core_done    = sched[c];
      abort        = (c == abort_at);
      step();
      core_done      = '0;
      abort          = 1'b0;
      obs_mask[c]    = done_mask;
      obs_status[c]  = status;
      obs_alldone[c] = all_done;
      if (status != 2'b01) begin
        end_cyc = c;
        return;
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    chk_cnt++; if (status !== 2'b00) $display("FAIL reset_status got %b want 00", status); else pass_cnt++;
    chk_cnt++; if (core_start !== 4'b0) $display("FAIL reset_start got %b want 0000", core_start); else pass_cnt++;
    chk_cnt++; if (done_mask !== 4'b0) $display("FAIL reset_mask got %b want 0000", done_mask); else pass_cnt++;
    chk_cnt++; if (all_done !== 1'b0 || cycle_count !== 16'd0) $display("FAIL reset_misc got %b/%0d want 0/0", all_done, cycle_count); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    // reset in the middle of a run, checked before any further clock edge
    clear_sched();
    timeout_limit = '0;
    sched[1] = 4'b0001;
    start_run(4'b1111);
    run_process(2);
    chk_cnt++; if (status !== 2'b01 || done_mask !== 4'b0001) $display("FAIL pre_reset got %b/%b want 01/0001", status, done_mask); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (status !== 2'b00) $display("FAIL async_status got %b want 00", status); else pass_cnt++;
    chk_cnt++; if (done_mask !== 4'b0) $display("FAIL async_mask got %b want 0000", done_mask); else pass_cnt++;
    chk_cnt++; if (core_start !== 4'b0 || cycle_count !== 16'd0) $display("FAIL async_misc got %b/%0d want 0000/0", core_start, cycle_count); else pass_cnt++;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_normal();
    logic [NC-1:0] m;
    clear_sched();
    timeout_limit = '0;
    sched[3] = 4'b0100; sched[5] = 4'b0001; sched[6] = 4'b1000; sched[9] = 4'b0010;
    exp_q.push_back({2'b11, 4'b1111, 16'd9});
    start_run(4'b1111);
    run_process(20);
    chk_cnt++; if (end_cyc !== 9) $display("FAIL normal_end got %0d want 9", end_cyc); else pass_cnt++;
    chk_cnt++; if (obs_start[1] !== 4'b1111) $display("FAIL normal_start1 got %b want 1111", obs_start[1]); else pass_cnt++;
    chk_cnt++; if (obs_start[2] !== 4'b0000) $display("FAIL normal_start2 got %b want 0000", obs_start[2]); else pass_cnt++;
    m = '0;
    for (int c = 1; c <= 9 && c <= end_cyc; c++) begin
      m = m | sched[c];
      chk_cnt++; if (obs_mask[c] !== m) $display("FAIL normal_mask_c%0d got %b want %b", c, obs_mask[c], m); else pass_cnt++;
    end
    chk_cnt++; if (obs_alldone[9] !== 1'b1) $display("FAIL normal_alldone got %b want 1", obs_alldone[9]); else pass_cnt++;
    got_w = {status, done_mask, cycle_count};
    exp_w = exp_q.pop_front();
    chk_cnt++; if (got_w !== exp_w) $display("FAIL normal_sb got %h want %h", got_w, exp_w); else pass_cnt++;
    step();
    chk_cnt++; if (all_done !== 1'b0 || status !== 2'b11) $display("FAIL normal_hold got %b/%b want 0/11", all_done, status); else pass_cnt++;
    do_clear();
  endtask

  task automatic test_partial();
    clear_sched();
    timeout_limit = '0;
    sched[1] = 4'b1010; sched[2] = 4'b1010; sched[3] = 4'b1010; sched[4] = 4'b1111;
    exp_q.push_back({2'b11, 4'b0101, 16'd4});
    start_run(4'b0101);
    run_process(12);
    chk_cnt++; if (end_cyc !== 4) $display("FAIL partial_end got %0d want 4", end_cyc); else pass_cnt++;
    for (int c = 1; c <= 3 && c <= end_cyc; c++) begin
      chk_cnt++; if (obs_mask[c] !== 4'b0000) $display("FAIL partial_mask_c%0d got %b want 0000", c, obs_mask[c]); else pass_cnt++;
    end
    got_w = {status, done_mask, cycle_count};
    exp_w = exp_q.pop_front();
    chk_cnt++; if (got_w !== exp_w) $display("FAIL partial_sb got %h want %h", got_w, exp_w); else pass_cnt++;
    do_clear();
  endtask

  task automatic test_timeout();
    clear_sched();
    timeout_limit = 16'd10;
    sched[2] = 4'b0001;
    exp_q.push_back({2'b10, 4'b0001, 16'd10});
    start_run(4'b1111);
    run_process(20);
    chk_cnt++; if (end_cyc !== 10) $display("FAIL timeout_end got %0d want 10", end_cyc); else pass_cnt++;
    chk_cnt++; if (all_done !== 1'b0) $display("FAIL timeout_alldone got %b want 0", all_done); else pass_cnt++;
    got_w = {status, done_mask, cycle_count};
    exp_w = exp_q.pop_front();
    chk_cnt++; if (got_w !== exp_w) $display("FAIL timeout_sb got %h want %h", got_w, exp_w); else pass_cnt++;
    do_clear();
    // completion on the timeout cycle wins
    clear_sched();
    sched[2] = 4'b0001; sched[10] = 4'b1110;
    exp_q.push_back({2'b11, 4'b1111, 16'd10});
    start_run(4'b1111);
    run_process(20);
    chk_cnt++; if (end_cyc !== 10) $display("FAIL race_end got %0d want 10", end_cyc); else pass_cnt++;
    got_w = {status, done_mask, cycle_count};
    exp_w = exp_q.pop_front();
    chk_cnt++; if (got_w !== exp_w) $display("FAIL race_sb got %h want %h", got_w, exp_w); else pass_cnt++;
    do_clear();
    timeout_limit = '0;
  endtask

  task automatic test_abort_clear();
    clear_sched();
    timeout_limit = '0;
    sched[1] = 4'b0010;
    abort_at = 3;
    exp_q.push_back({2'b00, 4'b0010, 16'd3});
    start_run(4'b1111);
    run_process(12);
    chk_cnt++; if (end_cyc !== 3) $display("FAIL abort_end got %0d want 3", end_cyc); else pass_cnt++;
    got_w = {status, done_mask, cycle_count};
    exp_w = exp_q.pop_front();
    chk_cnt++; if (got_w !== exp_w) $display("FAIL abort_sb got %h want %h", got_w, exp_w); else pass_cnt++;
    step();
    chk_cnt++; if (cycle_count !== 16'd3 || status !== 2'b00) $display("FAIL abort_hold got %0d/%b want 3/00", cycle_count, status); else pass_cnt++;
    // reach ALLDONE, then begin alone is ignored and clear+begin only returns to IDLE
    clear_sched();
    sched[1] = 4'b0001;
    start_run(4'b0001);
    run_process(4);
    chk_cnt++; if (status !== 2'b11 || cycle_count !== 16'd1) $display("FAIL quick_run got %b/%0d want 11/1", status, cycle_count); else pass_cnt++;
    core_enable   = 4'b0110;
    begin_process = 1'b1;
    step();
    chk_cnt++; if (status !== 2'b11 || core_start !== 4'b0) $display("FAIL begin_in_done got %b/%b want 11/0000", status, core_start); else pass_cnt++;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_cnt++; if (status !== 2'b00 || core_start !== 4'b0) $display("FAIL clear_begin got %b/%b want 00/0000", status, core_start); else pass_cnt++;
    step();
    begin_process = 1'b0;
    chk_cnt++; if (status !== 2'b01 || core_start !== 4'b0110) $display("FAIL restart got %b/%b want 01/0110", status, core_start); else pass_cnt++;
    clear_sched();
    sched[1] = 4'b0110;
    exp_q.push_back({2'b11, 4'b0110, 16'd1});
    run_process(4);
    got_w = {status, done_mask, cycle_count};
    exp_w = exp_q.pop_front();
    chk_cnt++; if (got_w !== exp_w) $display("FAIL restart_sb got %h want %h", got_w, exp_w); else pass_cnt++;
    do_clear();
  endtask

  task automatic test_zero_enable();
    core_done = 4'b1111;
    start_run(4'b0000);
    core_done = '0;
    chk_cnt++; if (status !== 2'b11) $display("FAIL zero_status got %b want 11", status); else pass_cnt++;
    chk_cnt++; if (all_done !== 1'b1 || core_start !== 4'b0) $display("FAIL zero_pulse got %b/%b want 1/0000", all_done, core_start); else pass_cnt++;
    chk_cnt++; if (cycle_count !== 16'd0 || done_mask !== 4'b0) $display("FAIL zero_cnt got %0d/%b want 0/0000", cycle_count, done_mask); else pass_cnt++;
    step();
    chk_cnt++; if (all_done !== 1'b0 || core_start !== 4'b0) $display("FAIL zero_after got %b/%b want 0/0000", all_done, core_start); else pass_cnt++;
    do_clear();
  endtask

  task automatic test_back_to_back();
    logic [NC-1:0] en;
    logic [NC-1:0] m;
    logic [1:0]    st;
    int            e;
    for (int r = 0; r < 8; r++) begin
      clear_sched();
      en = NC'($urandom_range(1, 15));
      timeout_limit = (r % 2 == 0) ? 16'd0 : CW'($urandom_range(3, 8));
      for (int c = 1; c <= 12; c++) sched[c] = NC'($urandom_range(0, 15)) & NC'($urandom_range(0, 15));
      if (timeout_limit == 16'd0) sched[12] = 4'b1111;
      m = '0; st = 2'b01; e = 0;
      for (int c = 1; c <= 12 && e == 0; c++) begin
        m = m | (sched[c] & en);
        if (m == en) begin st = 2'b11; e = c; end
        else if (timeout_limit != 16'd0 && c == int'(timeout_limit)) begin st = 2'b10; e = c; end
      end
      exp_q.push_back({st, m, CW'(e)});
      start_run(en);
      run_process(20);
      chk_cnt++; if (end_cyc !== e) $display("FAIL rand%0d_end got %0d want %0d", r, end_cyc, e); else pass_cnt++;
      got_w = {status, done_mask, cycle_count};
      exp_w = exp_q.pop_front();
      chk_cnt++; if (got_w !== exp_w) $display("FAIL rand%0d_sb got %h want %h", r, got_w, exp_w); else pass_cnt++;
      do_clear();
    end
    timeout_limit = '0;
  endtask

  initial begin
    pass_cnt      = 0;
    chk_cnt       = 0;
    rst_n         = 1'b0;
    begin_process = 1'b0;
    core_enable   = '0;
    core_done     = '0;
    clear         = 1'b0;
    abort         = 1'b0;
    timeout_limit = '0;
    abort_at      = 0;
    test_reset();
    test_normal();
    test_partial();
    test_timeout();
    test_abort_clear();
    test_zero_enable();
    test_back_to_back();
    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/multicore_controller.md
Name: multicore_controller

Overview:
- Top-level sequencer for the multi-core matrix-multiply array; generalises the single-flag process/alldone controller to NUM_CORES cores.
- Launches the enabled cores, tracks per-core completion with sticky flags, reports aggregate status, and supervises a programmable cycle timeout.
- Sits between the host/testbench command interface and the core array.

Parameters:
NUM_CORES, 4, number of processing cores supervised (1..32)
CNT_W, 16, width of cycle counter and timeout limit

Ports:
clock  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
begin_process  input  1  start request, sampled in IDLE
core_enable  input  NUM_CORES  cores taking part; latched on accepted start
core_done  input  NUM_CORES  per-core completion level/pulse
clear  input  1  return from ALLDONE/TIMEOUT to IDLE
abort  input  1  cancel a run in PROCESS
timeout_limit  input  CNT_W  max PROCESS cycles; 0 = timeout disabled
core_start  output  NUM_CORES  one-cycle start pulse per enabled core
status  output  2  00 IDLE, 01 PROCESS, 10 TIMEOUT, 11 ALLDONE
done_mask  output  NUM_CORES  sticky per-core done flags
all_done  output  1  one-cycle pulse on entry to ALLDONE
cycle_count  output  CNT_W  cycles spent in current/last run, saturating

Behaviour:
- One clock, asynchronous active-low reset: rst_n low forces state IDLE immediately; status=00, core_start=0, done_mask=0, all_done=0, cycle_count=0, enable latch=0. Reset mid-run discards the run.
- All outputs registered; status equals the state encoding.
- IDLE: begin_process=1 with core_enable!=0 -> PROCESS next edge; latch core_enable, clear done_mask and cycle_count, drive core_start=core_enable for exactly that first PROCESS cycle.
- IDLE with begin_process=1 and core_enable=0 -> ALLDONE directly; no core_start, all_done pulses, cycle_count=0.
- PROCESS: each cycle done_mask <= done_mask | (core_done & en_latch); core_done on unenabled cores is ignored. cycle_count increments by 1 per PROCESS cycle, saturating at all-ones.
- Completion: when (done_mask | core_done & en_latch) == en_latch -> ALLDONE next edge, all_done=1 for one cycle. A core_done arriving in the first PROCESS cycle counts.
- Timeout: if timeout_limit!=0 and cycle_count+1 == timeout_limit with completion not reached -> TIMEOUT. Completion and timeout in the same cycle: completion wins.
- abort=1 in PROCESS -> IDLE; done_mask and cycle_count retained for inspection. abort has priority over completion and timeout. abort is ignored outside PROCESS.
- ALLDONE/TIMEOUT: hold state, done_mask and cycle_count. clear=1 -> IDLE. begin_process is ignored here. clear and begin_process together: go to IDLE; the start is taken only on a later cycle.
- begin_process held high across IDLE re-entry starts a new run; no edge detection.
- inputs clear/abort outside their states: no effect.

Decomposition:
- Shared package mc_pkg: state/status encodings (ST_IDLE=2'b00, ST_PROCESS=2'b01, ST_TIMEOUT=2'b10, ST_ALLDONE=2'b11), default NUM_CORES/CNT_W constants.
- One natural sub-module: done_tracker (sticky mask, enable latch, all-done compare), instantiated once; FSM, counter and start-pulse logic stay in the top.

Test Plan:
- Reset/idle: rst_n low mid-PROCESS with NUM_CORES=4 -> status=00, done_mask=0, core_start=0 within the same cycle, no clock edge needed.
- Normal run: core_enable=4'b1111, begin pulse, core_done pulses on cores 2,0,3,1 at cycles 3,5,6,9 -> core_start=1111 for one cycle, done_mask builds 0100,0101,1101,1111; all_done one pulse; status=11; cycle_count=9.
- Partial enable: core_enable=4'b0101, core_done=4'b1010 held, then cores 0,2 done at cycle 4 -> bits 1,3 never set; ALLDONE after cycle 4.
- Timeout: timeout_limit=10, only core 0 done -> status=10 after 10 PROCESS cycles; same run with last core_done on cycle 10 -> status=11, not 10.
- Abort/clear: abort at cycle 3 -> IDLE with cycle_count=3 held; in ALLDONE assert clear+begin together -> IDLE, no core_start; begin next cycle -> new run.
- Zero enable: core_enable=0, begin -> ALLDONE next edge, all_done pulse, core_start never asserted.
